// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl - exception / interrupt initiator at the MEM/commit stage.
//
// Ranks the per-instruction exception flags and the pending interrupt by
// priority. For an accepted event it sends CP0 a one-cycle one-hot commit,
// carrying the faulting PC, the delay-slot flag and the bad address. It then
// flushes IF..MEM and redirects fetch, through a valid/ready handshake, to the
// exception vector, or to EPC for ERET.
//
// Ports
//   clk, rst             clock (posedge), asynchronous active-low reset
//   MemValid_i           valid instruction in MEM
//   MemPC_i              PC of the MEM instruction
//   MemInDelaySlot_i     MEM instruction sits in a branch delay slot
//   MemExc_i[7:0]        IF AdEL, RI, Ov, Syscall, Break, ld AdEL, st AdES, ERET
//   MemVAddr_i           data virtual address of the MEM instruction
//   CP0Status_i/Cause_i/EPC_i  current CP0 register values
//   HwInt_i[5:0]         asynchronous external interrupt lines
//   TimerInt_i           CP0 timer interrupt (clk domain)
//   ExceptType_o[8:0]    one-hot commit to CP0 (Int, IF AdEL, ..., ERET)
//   ExcPC_o              faulting instruction PC
//   IsDelaySlot_o        delay-slot flag of the event
//   BadVAddr_o           bad address for address-error events, else 0
//   HwIntSync_o[5:0]     synchronised HwInt_i for Cause.IP[7:2]
//   Flush_o              kill IF..MEM
//   RedirectValid_o      RedirectPC_o is valid
//   RedirectPC_o         fetch redirect target
//   RedirectReady_i      IF accepts the redirect
//   Busy_o               FSM is not in IDLE
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemValid_i,
  input  logic [31:0] MemPC_i,
  input  logic        MemInDelaySlot_i,
  input  logic [7:0]  MemExc_i,
  input  logic [31:0] MemVAddr_i,
  input  logic [31:0] CP0Status_i,
  input  logic [31:0] CP0Cause_i,
  input  logic [31:0] CP0EPC_i,
  input  logic [5:0]  HwInt_i,
  input  logic        TimerInt_i,
  output logic [8:0]  ExceptType_o,
  output logic [31:0] ExcPC_o,
  output logic        IsDelaySlot_o,
  output logic [31:0] BadVAddr_o,
  output logic [5:0]  HwIntSync_o,
  output logic        Flush_o,
  output logic        RedirectValid_o,
  output logic [31:0] RedirectPC_o,
  input  logic        RedirectReady_i,
  output logic        Busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][5:0] sync_q;

  logic [8:0]  exc_type_q, exc_type_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic        dslot_q, dslot_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic [31:0] target_q, target_d;
  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rpc_q, rpc_d;
  logic        busy_q, busy_d;

  logic [7:0] ip_w;
  logic       int_pend;
  logic [8:0] req;
  logic [8:0] sel;

  // Status/Cause bits that play no part in interrupt qualification.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{CP0Status_i[31:16], CP0Status_i[7:2],
                             CP0Cause_i[31:10], CP0Cause_i[7:0]};

  // Event detection: IP vector aligned {IP7..IP2, IP1, IP0} against IM[15:8];
  // the timer shares IP7 with HwInt[5].
  always_comb begin
    ip_w     = {sync_q[SYNC_STAGES-1][5] | TimerInt_i,
                sync_q[SYNC_STAGES-1][4:0], CP0Cause_i[9:8]};
    int_pend = CP0Status_i[0] & ~CP0Status_i[1] & (|(ip_w & CP0Status_i[15:8]));
    // Bit order of req already matches the ExceptType one-hot, lowest bit
    // highest priority, so isolating the lowest set bit selects the winner.
    req      = {MemExc_i, int_pend};
    sel      = req & (~req + 9'd1);
  end

  always_comb begin
    state_d     = state_q;
    exc_type_d  = 9'd0;
    exc_pc_d    = exc_pc_q;
    dslot_d     = dslot_q;
    bad_vaddr_d = bad_vaddr_q;
    target_d    = target_q;
    flush_d     = 1'b0;
    rvalid_d    = 1'b0;
    rpc_d       = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (MemValid_i && (sel != 9'd0)) begin
          state_d    = COMMIT;
          exc_type_d = sel;
          exc_pc_d   = MemPC_i;
          dslot_d    = MemInDelaySlot_i;
          if (sel[1])
            bad_vaddr_d = MemPC_i;
          else if (sel[6] || sel[7])
            bad_vaddr_d = MemVAddr_i;
          else
            bad_vaddr_d = 32'd0;
          target_d   = sel[8] ? CP0EPC_i : EXC_VECTOR;
          flush_d    = 1'b1;
        end
      end
      COMMIT: begin
        state_d  = REDIRECT;
        flush_d  = 1'b1;
        rvalid_d = 1'b1;
        rpc_d    = target_q;
      end
      REDIRECT: begin
        if (RedirectReady_i) begin
          state_d = IDLE;
        end else begin
          flush_d  = 1'b1;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Registered state, outputs and HwInt synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      exc_type_q  <= 9'd0;
      exc_pc_q    <= 32'd0;
      dslot_q     <= 1'b0;
      bad_vaddr_q <= 32'd0;
      target_q    <= 32'd0;
      flush_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rpc_q       <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q[0]   <= HwInt_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      exc_type_q  <= exc_type_d;
      exc_pc_q    <= exc_pc_d;
      dslot_q     <= dslot_d;
      bad_vaddr_q <= bad_vaddr_d;
      target_q    <= target_d;
      flush_q     <= flush_d;
      rvalid_q    <= rvalid_d;
      rpc_q       <= rpc_d;
      busy_q      <= busy_d;
    end
  end

  assign ExceptType_o    = exc_type_q;
  assign ExcPC_o         = exc_pc_q;
  assign IsDelaySlot_o   = dslot_q;
  assign BadVAddr_o      = bad_vaddr_q;
  assign HwIntSync_o     = sync_q[SYNC_STAGES-1];
  assign Flush_o         = flush_q;
  assign RedirectValid_o = rvalid_q;
  assign RedirectPC_o    = rpc_q;
  assign Busy_o          = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          SS  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemValid_i;
  logic [31:0] MemPC_i;
  logic        MemInDelaySlot_i;
  logic [7:0]  MemExc_i;
  logic [31:0] MemVAddr_i;
  logic [31:0] CP0Status_i, CP0Cause_i, CP0EPC_i;
  logic [5:0]  HwInt_i;
  logic        TimerInt_i;
  logic [8:0]  ExceptType_o;
  logic [31:0] ExcPC_o;
  logic        IsDelaySlot_o;
  logic [31:0] BadVAddr_o;
  logic [5:0]  HwIntSync_o;
  logic        Flush_o;
  logic        RedirectValid_o;
  logic [31:0] RedirectPC_o;
  logic        RedirectReady_i;
  logic        Busy_o;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .MemValid_i(MemValid_i), .MemPC_i(MemPC_i), .MemInDelaySlot_i(MemInDelaySlot_i),
    .MemExc_i(MemExc_i), .MemVAddr_i(MemVAddr_i),
    .CP0Status_i(CP0Status_i), .CP0Cause_i(CP0Cause_i), .CP0EPC_i(CP0EPC_i),
    .HwInt_i(HwInt_i), .TimerInt_i(TimerInt_i),
    .ExceptType_o(ExceptType_o), .ExcPC_o(ExcPC_o), .IsDelaySlot_o(IsDelaySlot_o),
    .BadVAddr_o(BadVAddr_o), .HwIntSync_o(HwIntSync_o), .Flush_o(Flush_o),
    .RedirectValid_o(RedirectValid_o), .RedirectPC_o(RedirectPC_o),
    .RedirectReady_i(RedirectReady_i), .Busy_o(Busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 commit pulse, 2 waiting for IF.
  int          m_ph;
  logic [8:0]  m_type;
  logic [31:0] m_pc, m_bad, m_tgt;
  logic        m_ds;
  logic [5:0]  m_q[$];   // HwInt history; m_q[0] is what the synchroniser shows

  task automatic m_reset();
    m_ph = 0; m_type = '0; m_pc = '0; m_bad = '0; m_tgt = '0; m_ds = 1'b0;
    m_q.delete();
    for (int i = 0; i < SS; i++) m_q.push_back(6'h00);
  endtask

  task automatic model_edge();
    logic [5:0] hs;
    logic [7:0] ip;
    logic       irq;
    logic [8:0] flags;
    int         win;
    hs    = m_q[0];
    ip    = {hs[5] | TimerInt_i, hs[4:0], CP0Cause_i[9:8]};
    irq   = CP0Status_i[0] && !CP0Status_i[1] && ((ip & CP0Status_i[15:8]) != 8'h00);
    flags = {MemExc_i, irq};   // priority order: interrupt first, ERET last
    win   = -1;
    for (int i = 8; i >= 0; i--) if (flags[i]) win = i;
    case (m_ph)
      0: if (MemValid_i && win >= 0) begin
           m_ph   = 1;
           m_type = 9'd1 << win;
           m_pc   = MemPC_i;
           m_ds   = MemInDelaySlot_i;
           m_bad  = (win == 1) ? MemPC_i : ((win == 6 || win == 7) ? MemVAddr_i : 32'd0);
           m_tgt  = (win == 8) ? CP0EPC_i : VEC;
         end
      1: m_ph = 2;
      default: if (RedirectReady_i) m_ph = 0;
    endcase
    m_q.push_back(HwInt_i);
    void'(m_q.pop_front());
  endtask

  task automatic check_outs();
    chk("type",   ExceptType_o,    (m_ph == 1) ? {23'd0, m_type} : 32'd0);
    chk("flush",  Flush_o,         (m_ph != 0) ? 32'd1 : 32'd0);
    chk("rvalid", RedirectValid_o, (m_ph == 2) ? 32'd1 : 32'd0);
    chk("busy",   Busy_o,          (m_ph != 0) ? 32'd1 : 32'd0);
    chk("hwsync", HwIntSync_o,     m_q[0]);
    if (m_ph == 1) begin
      chk("excpc", ExcPC_o, m_pc);
      chk("dslot", IsDelaySlot_o, m_ds);
      chk("badva", BadVAddr_o, m_bad);
    end
    if (m_ph == 2) chk("rpc", RedirectPC_o, m_tgt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle_inputs();
    MemValid_i = 1'b0; MemPC_i = '0; MemInDelaySlot_i = 1'b0; MemExc_i = '0;
    MemVAddr_i = '0; CP0Status_i = '0; CP0Cause_i = '0; CP0EPC_i = '0;
    HwInt_i = '0; TimerInt_i = 1'b0; RedirectReady_i = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_type"},   ExceptType_o, 0);
    chk({tag, "_excpc"},  ExcPC_o, 0);
    chk({tag, "_dslot"},  IsDelaySlot_o, 0);
    chk({tag, "_badva"},  BadVAddr_o, 0);
    chk({tag, "_hwsync"}, HwIntSync_o, 0);
    chk({tag, "_flush"},  Flush_o, 0);
    chk({tag, "_rvalid"}, RedirectValid_o, 0);
    chk({tag, "_rpc"},    RedirectPC_o, 0);
    chk({tag, "_busy"},   Busy_o, 0);
  endtask

  task automatic syscall_case(input string tag);
    MemValid_i = 1'b1; MemPC_i = 32'hBFC0_0100; MemInDelaySlot_i = 1'b0;
    MemExc_i = 8'h08; RedirectReady_i = 1'b1;
    cyc();
    MemValid_i = 1'b0; MemExc_i = 8'h00;
    chk({tag, "_type"}, ExceptType_o, 9'h010);
    chk({tag, "_pc"}, ExcPC_o, 32'hBFC0_0100);
    cyc();
    chk({tag, "_typeoff"}, ExceptType_o, 9'h000);
    chk({tag, "_rpc"}, RedirectPC_o, 32'hBFC0_0380);
    cyc();
    chk({tag, "_flush"}, Flush_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    cyc();

    // Case 1: syscall
    syscall_case("c1");

    // Case 2: RI, Ov and Break together in a delay slot
    MemValid_i = 1'b1; MemPC_i = 32'h8000_1000; MemInDelaySlot_i = 1'b1; MemExc_i = 8'h16;
    cyc();
    MemValid_i = 1'b0; MemExc_i = 8'h00; MemInDelaySlot_i = 1'b0;
    chk("c2_type", ExceptType_o, 9'h004);
    chk("c2_ds", IsDelaySlot_o, 1'b1);
    repeat (2) cyc();

    // Case 3: store AdES
    MemValid_i = 1'b1; MemPC_i = 32'h8000_2000; MemVAddr_i = 32'h8000_0003; MemExc_i = 8'h40;
    cyc();
    MemValid_i = 1'b0; MemExc_i = 8'h00;
    chk("c3_bad", BadVAddr_o, 32'h8000_0003);
    chk("c3_type", ExceptType_o, 9'h080);
    repeat (2) cyc();

    // Case 4: ERET with a stalled redirect; a Break in the meantime is dropped
    MemValid_i = 1'b1; MemPC_i = 32'h8000_3000; MemExc_i = 8'h80;
    CP0EPC_i = 32'hBFC0_0200; RedirectReady_i = 1'b0;
    cyc();
    chk("c4_type", ExceptType_o, 9'h100);
    MemExc_i = 8'h10;
    cnt = 0;
    for (int i = 0; i < 10 && (i == 0 || RedirectValid_o); i++) begin
      cyc();
      if (RedirectValid_o) begin
        cnt++;
        chk("c4_rpc", RedirectPC_o, 32'hBFC0_0200);
      end
      if (cnt >= 3) begin MemValid_i = 1'b0; MemExc_i = 8'h00; end
      RedirectReady_i = (cnt >= 5);
    end
    chk("c4_rv_cycles", cnt, 5);
    chk("c4_idle_type", ExceptType_o, 9'h000);
    RedirectReady_i = 1'b1;
    cyc();

    // Case 5: hardware interrupt through the synchroniser
    CP0Status_i = 32'h0000_0401; MemValid_i = 1'b1; MemPC_i = 32'h8000_4000; HwInt_i = 6'h01;
    repeat (SS) cyc();
    chk("c5_early", ExceptType_o, 9'h000);
    cyc();
    chk("c5_type", ExceptType_o, 9'h001);
    MemValid_i = 1'b0;
    repeat (3) cyc();
    CP0Status_i = 32'h0000_0403; MemValid_i = 1'b1;
    repeat (SS + 2) cyc();
    chk("c5_exl_busy", Busy_o, 1'b0);
    HwInt_i = 6'h00; CP0Status_i = 32'h0; MemValid_i = 1'b0;
    repeat (SS + 1) cyc();

    // Case 6: reset in REDIRECT
    MemValid_i = 1'b1; MemPC_i = 32'h8000_5000; MemExc_i = 8'h08; RedirectReady_i = 1'b0;
    cyc();
    MemValid_i = 1'b0; MemExc_i = 8'h00;
    cyc();
    chk("c6_in_redirect", RedirectValid_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("c6");
    m_reset();
    @(negedge clk) rst = 1'b1;
    cyc();
    syscall_case("c6_after");

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      MemValid_i       = ($urandom_range(0, 3) != 0);
      MemPC_i          = $urandom & 32'hFFFF_FFFC;
      MemInDelaySlot_i = 1'($urandom_range(0, 1));
      MemExc_i         = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      MemVAddr_i       = $urandom;
      CP0Status_i      = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      CP0Cause_i       = {22'h0, 2'($urandom), 8'h0};
      CP0EPC_i         = $urandom;
      if ($urandom_range(0, 7) == 0) HwInt_i = 6'($urandom);
      TimerInt_i       = ($urandom_range(0, 7) == 0);
      RedirectReady_i  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt initiator. It sits at the MEM/commit stage and drives the exception side of the CP0 register block. It sorts the per-instruction exception flags and the external interrupt lines by priority. For each accepted event it sends CP0 a one-cycle, one-hot exception-type commit carrying the faulting PC, the delay-slot flag and the bad address. It then flushes the pipeline and redirects fetch, through a valid/ready handshake, to either the exception vector or EPC (for ERET).

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt.
- SYNC_STAGES, 2, synchroniser depth on HwInt_i (legal values 2..3).

Ports:
- clk  in  1  clock; every flop is on posedge.
- rst  in  1  reset, asynchronous, active-low.
- MemValid_i  in  1  a valid instruction occupies MEM this cycle.
- MemPC_i  in  32  PC of the MEM instruction.
- MemInDelaySlot_i  in  1  the MEM instruction is in a branch delay slot.
- MemExc_i  in  8  exception flags: [0] IF AdEL, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] load AdEL, [6] store AdES, [7] ERET.
- MemVAddr_i  in  32  data virtual address of the MEM instruction.
- CP0Status_i, CP0Cause_i, CP0EPC_i  in  32 each  current CP0 register values.
- HwInt_i  in  6  external interrupt lines, asynchronous.
- TimerInt_i  in  1  CP0 timer interrupt, synchronous to clk.
- ExceptType_o  out  9  one-hot to CP0: [0] Interrupt, [1] IF AdEL, [2] RI, [3] Ov, [4] Syscall, [5] Break, [6] load AdEL, [7] store AdES, [8] ERET.
- ExcPC_o  out  32  faulting instruction PC. CP0 derives EPC from it (minus 4 when in a delay slot).
- IsDelaySlot_o  out  1  delay-slot flag for the event.
- BadVAddr_o  out  32  MemPC_i for IF AdEL; MemVAddr_i for load AdEL and store AdES; 0 for every other event.
- HwIntSync_o  out  6  synchronised HwInt_i, which CP0 samples into Cause.IP[7:2].
- Flush_o  out  1  kill IF..MEM.
- RedirectValid_o  out  1  RedirectPC_o is valid.
- RedirectPC_o  out  32  fetch redirect target.
- RedirectReady_i  in  1  IF accepts the redirect.
- Busy_o  out  1  the FSM is not in IDLE.

## Operation
- Synchroniser: HwInt_i passes through a SYNC_STAGES-deep flop chain, giving HwIntSync_o.
- Interrupt pending when all of the following hold:
  - Status.IE (bit 0) = 1;
  - Status.EXL (bit 1) = 0;
  - ((Cause.IP[1:0] | {HwIntSync_o[5] | TimerInt_i, HwIntSync_o[4:0]}) & Status.IM[7:0]) != 0, with IP/IM bits aligned as {IP7..IP2, IP1, IP0} against IM[15:8].
- An interrupt is attached only to an instruction with MemValid_i = 1.
- Priority, highest first: Interrupt, IF AdEL, RI, Ov, Syscall, Break, load AdEL, store AdES, ERET. Only the highest-priority event is taken.
- FSM states:
  - IDLE → COMMIT: in IDLE, when MemValid_i = 1 and an event is selected. In that cycle, capture:
    - the type, PC, delay-slot flag and BadVAddr;
    - the target: CP0EPC_i for ERET, otherwise EXC_VECTOR.
  - COMMIT → REDIRECT: unconditionally.
  - REDIRECT → IDLE: when RedirectReady_i = 1.
- Outputs by state:
  - COMMIT: ExceptType_o = captured one-hot; ExcPC_o, IsDelaySlot_o and BadVAddr_o hold the captured values; Flush_o = 1.
  - REDIRECT: ExceptType_o = 0; Flush_o = 1; RedirectValid_o = 1; RedirectPC_o holds the captured target.
- Events arriving while not in IDLE are ignored; those instructions are being flushed.
- The FSM reacts to Status.EXL only as sampled in the detect cycle. Nested exceptions while EXL = 1 are still committed; CP0 decides whether to update EPC.

## Timing
- All outputs are registered.
- Reset (rst = 0, asynchronous): state IDLE, every output 0, synchroniser flops 0, capture registers 0. On reset release the FSM resumes from IDLE.
- Cycle N: detect. Cycle N+1: COMMIT, a single-cycle ExceptType_o pulse. Cycle N+2 onward: REDIRECT until the first cycle with RedirectReady_i = 1, call it M. Cycle M+1: IDLE; Flush_o, RedirectValid_o and Busy_o are 0.
- Minimum detect-to-IDLE time: 3 cycles. With RedirectReady_i held high, a new event can be detected in cycle N+3.
- RedirectPC_o and RedirectValid_o stay stable while RedirectReady_i = 0.
- If ERET and an interrupt both qualify in the same cycle, Interrupt wins and RedirectPC_o = EXC_VECTOR.
- An interrupt's latency from HwInt_i is SYNC_STAGES cycles of synchronisation plus the detect cycle.
- Asserting reset in COMMIT or REDIRECT drops every output to 0 immediately.

## Test plan
- Case 1:
  - Stimulus: Syscall at MemPC_i = 0xBFC0_0100, not in a delay slot, RedirectReady_i = 1.
  - Response: at N+1, ExceptType_o = 9'h010 for exactly one cycle, ExcPC_o = 0xBFC0_0100. At N+2, RedirectPC_o = 0xBFC0_0380. At N+3, Flush_o = 0.
- Case 2:
  - Stimulus: MemExc_i = 8'h16 (RI, Ov and Break at once) with MemInDelaySlot_i = 1.
  - Response: only RI is taken, ExceptType_o = 9'h004 and IsDelaySlot_o = 1.
- Case 3:
  - Stimulus: store AdES with MemVAddr_i = 0x8000_0003.
  - Response: BadVAddr_o = 0x8000_0003 and ExceptType_o = 9'h080.
- Case 4:
  - Stimulus: ERET with CP0EPC_i = 0xBFC0_0200, RedirectReady_i held low for 4 cycles.
  - Response: RedirectValid_o is high with RedirectPC_o = 0xBFC0_0200 for 5 cycles. A Break presented during that time is ignored.
- Case 5:
  - Stimulus: Status = 0x0000_0401 and HwInt_i[0] rises.
  - Response: after SYNC_STAGES + 1 cycles with MemValid_i = 1, ExceptType_o = 9'h001.
  - Repeat with Status.EXL = 1: no event.
- Case 6:
  - Stimulus: assert rst while in REDIRECT.
  - Response: every output is 0 immediately. After release, a fresh Syscall completes normally.
